ex_seq_check: RTL and testbench
===============================

Name: ex_seq_check

Overview:
- Receive-side checker for the 2-bit modulo-3 counter stream (0 -> 1 -> 2 -> 0 ...) produced by the cyclic sequence generator blocks in the pmux/ite test family.
- Samples the stream on a valid strobe and acquires lock after a run of legal transitions.
- Once locked, flags and counts each broken transition; drops lock on error and re-acquires.
- Sits at the consumer end of the generator's `res` output; used as a self-checking sink in equivalence and regression benches.

Parameters:
- LOCK_LEN, 3: consecutive consistent samples (including the first) needed to assert lock; legal range 2..15.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies in_num this cycle.
- in_num  input  2  sampled sequence value; 3 is illegal.
- clr_count  input  1  synchronous clear of err_count.
- locked  output  1  checker is locked to the sequence.
- err  output  1  one-cycle pulse on a broken transition while locked.
- err_count  output  ERR_W  saturating count of err pulses.
- expected  output  2  next value predicted; 0 in HUNT.

Behaviour:
- Reset is synchronous and active-high; one clock, clk. While reset=1 at a clk edge:
  - state <= HUNT; last <= 0; run <= 0.
  - locked, err, err_count, expected all <= 0.
  - Reset overrides all other inputs, including mid-lock and mid-run.
- next(v): 0->1, 1->2, 2->0. Never applied to 3.
- Internal state:
  - last (2b): previous accepted sample.
  - run: counter, width clog2(LOCK_LEN+1).
- Cycles with in_valid=0: no state change; err <= 0.
- All outputs are registered; each is updated on the edge that samples in_valid=1, i.e. 1-cycle latency.
- FSM states: HUNT, ACQ, LOCK.
- HUNT:
  - Valid sample with in_num<3: last <= in_num, run <= 1, go to ACQ.
  - in_num==3: stay in HUNT.
- ACQ:
  - in_num==next(last): last <= in_num; run <= run+1; if run+1==LOCK_LEN, go to LOCK.
  - in_num==3: go to HUNT, run <= 0.
  - Any other value: restart the run (last <= in_num, run <= 1, stay in ACQ).
  - Never asserts err.
- LOCK:
  - in_num==next(last): last <= in_num; stay in LOCK.
  - Mismatch (including 3):
    - err <= 1 for exactly one cycle; err_count increments.
    - If in_num==3: go to HUNT, run <= 0.
    - Otherwise: go to ACQ with last <= in_num, run <= 1.
- locked == (state==LOCK), registered. It deasserts on the same edge that raises err.
- expected:
  - In HUNT: 0.
  - Otherwise: next(last), reflecting the state after the edge.
- err_count:
  - Saturates at 2^ERR_W-1; further errors still pulse err.
  - clr_count has priority over an increment on the same edge: count <= 0, but err still pulses.
- A repeated value (e.g. 1,1) counts as a mismatch.
- Skipping a value (0->2) counts as a mismatch.

Test Plan:
- Reset, then valid stream 0,1,2,0,1 -> locked rises on the edge sampling the third value (2); expected=0 after it; err never set.
- Locked, then send 0 instead of 1 -> err=1 for one cycle, err_count=1, locked=0, state ACQ. Then 1,2 -> relock; expected=0.
- Locked, then send 3 -> err pulse, err_count=1, locked=0, expected=0 (HUNT). Then 3,3 -> remains in HUNT with no further err.
- ERR_W=2:
  - Force 5 lock/break cycles -> err_count holds at 3 while err pulses 5 times.
  - Assert clr_count on the 5th break edge -> count=0.
- Gaps: 0,(idle x4),1,(idle),2 -> locks identically to the gap-free case; idle cycles change nothing.
- Assert reset while locked with err_count=2 -> next edge: all outputs 0, HUNT. Then 2,0,1 -> locks after the third sample.

Source files
------------

// File: rtl/ex_seq_check.sv
// Receive-side checker for a modulo-3 (0->1->2->0) counter stream.
// Hunts for the sequence, locks after LOCK_LEN consistent samples, then flags and counts breaks.
module ex_seq_check #(
  parameter int LOCK_LEN = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       in_num,
  input  logic             clr_count,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       expected
);

  localparam int RUN_W = $clog2(LOCK_LEN + 1);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  function automatic logic [1:0] next_val(input logic [1:0] v);
    case (v)
      2'd0:    next_val = 2'd1;
      2'd1:    next_val = 2'd2;
      default: next_val = 2'd0;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [1:0]         last_q, last_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [RUN_W-1:0]   run_inc_s;
  logic               err_q, err_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic               locked_q, locked_d;
  logic [1:0]         expected_q, expected_d;
  logic               inc_s;

  assign run_inc_s = run_q + {{(RUN_W-1){1'b0}}, 1'b1};

  // Next-state, sample tracking and output prediction
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    run_d   = run_q;
    err_d   = 1'b0;
    inc_s   = 1'b0;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (in_num != 2'd3) begin
            last_d  = in_num;
            run_d   = {{(RUN_W-1){1'b0}}, 1'b1};
            state_d = ACQ;
          end else begin
            state_d = HUNT;
          end
        end
        ACQ: begin
          if (in_num == next_val(last_q)) begin
            last_d = in_num;
            run_d  = run_inc_s;
            if (run_inc_s == RUN_W'(LOCK_LEN)) begin
              state_d = LOCK;
            end else begin
              state_d = ACQ;
            end
          end else if (in_num == 2'd3) begin
            run_d   = {RUN_W{1'b0}};
            state_d = HUNT;
          end else begin
            last_d = in_num;
            run_d  = {{(RUN_W-1){1'b0}}, 1'b1};
          end
        end
        LOCK: begin
          if (in_num == next_val(last_q)) begin
            last_d = in_num;
          end else begin
            err_d = 1'b1;
            inc_s = 1'b1;
            if (in_num == 2'd3) begin
              run_d   = {RUN_W{1'b0}};
              state_d = HUNT;
            end else begin
              last_d  = in_num;
              run_d   = {{(RUN_W-1){1'b0}}, 1'b1};
              state_d = ACQ;
            end
          end
        end
        default: begin
          state_d = HUNT;
          last_d  = 2'd0;
          run_d   = {RUN_W{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // Clear wins over a same-edge increment; the err pulse is unaffected
    if (clr_count) begin
      err_count_d = {ERR_W{1'b0}};
    end else if (inc_s && (err_count_q != {ERR_W{1'b1}})) begin
      err_count_d = err_count_q + {{(ERR_W-1){1'b0}}, 1'b1};
    end else begin
      err_count_d = err_count_q;
    end

    locked_d   = (state_d == LOCK);
    expected_d = (state_d == HUNT) ? 2'd0 : next_val(last_d);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HUNT;
      last_q      <= 2'd0;
      run_q       <= {RUN_W{1'b0}};
      err_q       <= 1'b0;
      err_count_q <= {ERR_W{1'b0}};
      locked_q    <= 1'b0;
      expected_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      run_q       <= run_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
      locked_q    <= locked_d;
      expected_q  <= expected_d;
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign err_count = err_count_q;
  assign expected  = expected_q;

endmodule

// File: tb/tb_ex_seq_check.sv
// Self-checking bench for ex_seq_check: vector table, hand-written corner sequences,
// and randomized stimulus against a chain-length reference model (ERR_W=8 and ERR_W=2 instances).
module tb_ex_seq_check;

  localparam int LOCK_LEN = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] in_num = 2'd0;
  logic       clr_count = 1'b0;

  logic       locked_a, err_a;
  logic [7:0] cnt_a;
  logic [1:0] exp_a;
  logic       locked_b, err_b;
  logic [1:0] cnt_b;
  logic [1:0] exp_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_seq_check #(.LOCK_LEN(LOCK_LEN), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_num(in_num), .clr_count(clr_count),
    .locked(locked_a), .err(err_a), .err_count(cnt_a), .expected(exp_a)
  );

  ex_seq_check #(.LOCK_LEN(LOCK_LEN), .ERR_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_num(in_num), .clr_count(clr_count),
    .locked(locked_b), .err(err_b), .err_count(cnt_b), .expected(exp_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Checks both instances; c2 is the 2-bit instance's count
  task automatic chk_out(input string tag, input logic lk, input logic er, input int c8,
                         input int c2, input logic [1:0] ex);
    chk({tag, ".locked"},   {31'd0, locked_a}, {31'd0, lk});
    chk({tag, ".err"},      {31'd0, err_a},    {31'd0, er});
    chk({tag, ".count"},    {24'd0, cnt_a},    c8);
    chk({tag, ".expected"}, {30'd0, exp_a},    {30'd0, ex});
    chk({tag, ".locked2"},  {31'd0, locked_b}, {31'd0, lk});
    chk({tag, ".err2"},     {31'd0, err_b},    {31'd0, er});
    chk({tag, ".count2"},   {30'd0, cnt_b},    c2);
    chk({tag, ".expected2"},{30'd0, exp_b},    {30'd0, ex});
  endtask

  task automatic drive(input logic r, input logic v, input logic [1:0] n, input logic c);
    reset = r; in_valid = v; in_num = n; clr_count = c;
    @(posedge clk);
    #1;
  endtask

  // Reference model: length of the current consistent chain plus a lock flag
  int m_chain, m_last, m_cnt8, m_cnt2;
  bit m_locked, m_err;

  task automatic model_step(input logic r, input logic v, input logic [1:0] n, input logic c);
    int nx;
    m_err = 1'b0;
    if (r) begin
      m_locked = 1'b0; m_chain = 0; m_last = 0; m_cnt8 = 0; m_cnt2 = 0;
      return;
    end
    if (v) begin
      nx = (m_last + 1) % 3;
      if (m_locked) begin
        if (int'(n) != nx) begin
          m_err = 1'b1;
          m_locked = 1'b0;
          if (n == 2'd3) m_chain = 0;
          else begin m_chain = 1; m_last = int'(n); end
        end else m_last = int'(n);
      end else if (n == 2'd3) begin
        m_chain = 0;
      end else begin
        if (m_chain > 0 && int'(n) == nx) m_chain++;
        else m_chain = 1;
        m_last = int'(n);
        if (m_chain >= LOCK_LEN) m_locked = 1'b1;
      end
    end
    if (c) begin
      m_cnt8 = 0; m_cnt2 = 0;
    end else if (m_err) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  typedef struct {
    logic rst; logic vld; logic [1:0] num; logic clr;
    logic lk; logic er; int cnt; logic [1:0] ex;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int pulses;
    logic [1:0] n;
    logic r, v, c;
    logic [1:0] mex;

    tbl[0]  = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 0, 2'd0};
    tbl[1]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 0, 2'd1};
    tbl[2]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 0, 2'd2};
    tbl[3]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 0, 2'd0};
    tbl[4]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 0, 2'd1};
    tbl[5]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 0, 2'd2};
    tbl[6]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1, 2'd1};
    tbl[7]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1, 2'd2};
    tbl[8]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1, 2'd0};
    tbl[9]  = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 2, 2'd0};
    tbl[10] = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 2, 2'd0};
    tbl[11] = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 2, 2'd0};
    tbl[12] = '{1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 2, 2'd0};
    tbl[13] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 0, 2'd0};

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].num, tbl[i].clr);
      chk_out($sformatf("tbl%0d", i), tbl[i].lk, tbl[i].er, tbl[i].cnt,
              (tbl[i].cnt > 3) ? 3 : tbl[i].cnt, tbl[i].ex);
    end

    // Gapped stream locks exactly like the gap-free one
    drive(1'b1, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 1'b1, 2'd0, 1'b0);
    chk_out("gap.s0", 1'b0, 1'b0, 0, 0, 2'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 2'd3, 1'b0);
      chk_out($sformatf("gap.idle%0d", i), 1'b0, 1'b0, 0, 0, 2'd1);
    end
    drive(1'b0, 1'b1, 2'd1, 1'b0);
    chk_out("gap.s1", 1'b0, 1'b0, 0, 0, 2'd2);
    drive(1'b0, 1'b0, 2'd0, 1'b0);
    chk_out("gap.idle", 1'b0, 1'b0, 0, 0, 2'd2);
    drive(1'b0, 1'b1, 2'd2, 1'b0);
    chk_out("gap.lock", 1'b1, 1'b0, 0, 0, 2'd0);

    // Two breaks (repeat and skip), relock, then reset while locked
    drive(1'b0, 1'b1, 2'd1, 1'b0);
    chk_out("brk1", 1'b0, 1'b1, 1, 1, 2'd2);
    drive(1'b0, 1'b1, 2'd2, 1'b0);
    drive(1'b0, 1'b1, 2'd0, 1'b0);
    chk_out("relock1", 1'b1, 1'b0, 1, 1, 2'd1);
    drive(1'b0, 1'b1, 2'd0, 1'b0);
    chk_out("brk_repeat", 1'b0, 1'b1, 2, 2, 2'd1);
    drive(1'b0, 1'b1, 2'd1, 1'b0);
    drive(1'b0, 1'b1, 2'd2, 1'b0);
    chk_out("relock2", 1'b1, 1'b0, 2, 2, 2'd0);
    drive(1'b1, 1'b1, 2'd2, 1'b0);
    chk_out("rst_locked", 1'b0, 1'b0, 0, 0, 2'd0);
    drive(1'b0, 1'b1, 2'd2, 1'b0);
    drive(1'b0, 1'b1, 2'd0, 1'b0);
    chk_out("rst.s2", 1'b0, 1'b0, 0, 0, 2'd1);
    drive(1'b0, 1'b1, 2'd1, 1'b0);
    chk_out("rst.lock", 1'b1, 1'b0, 0, 0, 2'd2);

    // Five lock/break cycles: 2-bit count saturates, clear on the fifth break
    drive(1'b1, 1'b0, 2'd0, 1'b0);
    pulses = 0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 1'b1, 2'd0, 1'b0);
      drive(1'b0, 1'b1, 2'd1, 1'b0);
      drive(1'b0, 1'b1, 2'd2, 1'b0);
      chk($sformatf("sat%0d.locked", i), {31'd0, locked_b}, 32'd1);
      drive(1'b0, 1'b1, 2'd1, (i == 5) ? 1'b1 : 1'b0);
      if (err_b) pulses++;
      chk($sformatf("sat%0d.count2", i), {30'd0, cnt_b}, (i == 5) ? 0 : ((i > 3) ? 3 : i));
      chk($sformatf("sat%0d.count8", i), {24'd0, cnt_a}, (i == 5) ? 0 : i);
    end
    chk("sat.pulses", pulses, 32'd5);

    // Randomized stream against the reference model
    drive(1'b1, 1'b0, 2'd0, 1'b0);
    model_step(1'b1, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(99) == 0);
      v = ($urandom_range(9) < 7);
      c = ($urandom_range(99) < 3);
      if ($urandom_range(3) != 0) n = 2'((m_last + 1) % 3);
      else n = 2'($urandom_range(3));
      drive(r, v, n, c);
      model_step(r, v, n, c);
      mex = (m_locked || m_chain > 0) ? 2'((m_last + 1) % 3) : 2'd0;
      chk_out($sformatf("rnd%0d", i), m_locked, m_err, m_cnt8, m_cnt2, mex);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
